// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and constants for the nibble-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_add_pkg;

  localparam int NIBBLE_W          = 4;
  localparam int N_NIBBLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_rca.sv
// ============================================================================
// Module      : rca
// Description : 4-bit ripple-carry adder, time-shared by the serial controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rca
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] s,
  output logic                c_out
);

  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = c_in;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign c_out = w_c[NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module      : serial_add_ctrl
// Description : Valid/ready wrapped add/subtract, one nibble per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int N_NIBBLES = N_NIBBLES_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLE_W*N_NIBBLES-1:0] a,
  input  logic [NIBBLE_W*N_NIBBLES-1:0] b,
  input  logic                        c_in,
  input  logic                        op_sub,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLE_W*N_NIBBLES-1:0] sum,
  output logic                        c_out,
  output logic                        overflow
);

  localparam int W     = NIBBLE_W * N_NIBBLES;
  localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_NIBBLES - 1);

  state_t                                r_state;
  logic [N_NIBBLES-1:0][NIBBLE_W-1:0]    r_a;
  logic [N_NIBBLES-1:0][NIBBLE_W-1:0]    r_b;
  logic [N_NIBBLES-1:0][NIBBLE_W-1:0]    r_sum;
  logic [IDX_W-1:0]                      r_idx;
  logic                                  r_carry;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_s;
  logic                w_co;

  assign w_a_nib = r_a[r_idx];
  assign w_b_nib = r_b[r_idx];

  rca u_rca (
    .a     (w_a_nib),
    .b     (w_b_nib),
    .c_in  (r_carry),
    .s     (w_s),
    .c_out (w_co)
  );

  assign sum = r_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Subtract is A + ~B + 1, so the inversion and forced carry happen at capture.
            r_a      <= a;
            r_b      <= b ^ {W{op_sub}};
            r_carry  <= op_sub ? 1'b1 : c_in;
            r_idx    <= '0;
            in_ready <= 1'b0;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_sum[r_idx] <= w_s;
          r_carry      <= w_co;
          if (r_idx == C_LAST_IDX) begin
            c_out     <= w_co;
            overflow  <= (w_a_nib[NIBBLE_W-1] == w_b_nib[NIBBLE_W-1]) &&
                         (w_s[NIBBLE_W-1] != w_a_nib[NIBBLE_W-1]);
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl with N_NIBBLES = 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  localparam int NN = 4;
  localparam int W  = 4 * NN;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.N_NIBBLES(NN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ov;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Reference: unsigned result and signed range check straight from arithmetic.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic cin,
                       input logic sub, output logic [W-1:0] s, output logic co,
                       output logic ov);
    longint ua, ub, ur, sa, sb, sr;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = (ua >= 2**(W-1)) ? ua - 2**W : ua;
    sb = (ub >= 2**(W-1)) ? ub - 2**W : ub;
    if (sub) begin
      ur = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub + longint'(cin);
      co = (ur >= 2**W);
      sr = sa + sb + longint'(cin);
    end
    s  = W'(ur & (2**W - 1));
    ov = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1)));
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                        input logic ts, input logic [W-1:0] es, input logic ec,
                        input logic eo, input int hold, input string nm);
    int lat;
    @(negedge clk);
    a = ta; b = tbv; c_in = tc; op_sub = ts; in_valid = 1'b1;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " in_ready_before_accept"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    // Garbage on the inputs while busy must not disturb the operation.
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); op_sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    // out_valid is seen in the (NN+1)th cycle counting the accept cycle.
    chk({nm, " latency"}, 32'(lat), 32'(NN));
    chk({nm, " sum"}, 32'(sum), 32'(es));
    chk({nm, " c_out"}, 32'(c_out), 32'(ec));
    chk({nm, " overflow"}, 32'(overflow), 32'(eo));
    chk({nm, " in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
      @(posedge clk);
      #1;
      chk({nm, " hold_out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, " hold_sum"}, 32'(sum), 32'(es));
      chk({nm, " hold_c_out"}, 32'(c_out), 32'(ec));
      chk({nm, " hold_overflow"}, 32'(overflow), 32'(eo));
      chk({nm, " hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, " out_valid_after_hs"}, 32'(out_valid), 32'd0);
    chk({nm, " in_ready_after_hs"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] ra, rb, es;
    logic         rc, rs, ec, eo;
    int           lat;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; op_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset sum", 32'(sum), 32'd0);
    chk("reset c_out", 32'(c_out), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].exp_sum,
             vecs[i].exp_cout, vecs[i].exp_ov, 0, $sformatf("vec%0d", i));

    // Result held through three stalled cycles with in_valid pulses.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 3, "stall");

    // Reset in the second RUN cycle abandons the operation.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; c_in = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("abort accepted", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    lat = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    chk("abort no_result", 32'(lat), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rc, rs, es, ec, eo);
      run_op(ra, rb, rc, rs, es, ec, eo, (i % 5 == 0) ? 1 : 0, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
